// File: rtl/ws2812_encoder.sv
// rtl/ws2812_encoder.sv - WS2812 serial LED frame encoder
//
// Fetches 24-bit GRB words one at a time and serialises them MSB first as
// WS2812 high/low pulses, prefetching the next word into a one-word buffer,
// then holds the line low for the latch period.
//
// Ports:
//   clk_in           clock
//   rst_in           synchronous active-high reset
//   frame_start_in   one-cycle frame start pulse (ignored while busy)
//   word_cnt_in      LEDs in the frame, sampled with frame_start_in, clamped to 64
//   word_req_out     one-cycle word request
//   word_idx_out     index of the requested word
//   word_rdy_in      one-cycle strobe, word_data_in valid for the outstanding request
//   word_data_in     GRB pixel word
//   ws2812_data_out  serial waveform
//   busy_out         frame in progress
//   done_out         one-cycle frame completion pulse
//   underrun_out     sticky: a word arrived too late to avoid a gap
module ws2812_encoder #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 63,
  parameter int RST_CYC = 4000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic [6:0]  word_cnt_in,
  output logic        word_req_out,
  output logic [5:0]  word_idx_out,
  input  logic        word_rdy_in,
  input  logic [23:0] word_data_in,
  output logic        ws2812_data_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        underrun_out
);

  localparam int CYC_W = $clog2(BIT_CYC + 1);
  localparam int LAT_W = $clog2(RST_CYC + 1);

  localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYC);
  localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYC);
  localparam logic [CYC_W-1:0] BIT_LAST = CYC_W'(BIT_CYC - 1);
  // The line output is registered, so it lags the state by one cycle; letting
  // the latch counter run to RST_CYC gives RST_CYC full low cycles on the line
  // after the last bit period before done_out rises.
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RST_CYC);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t           state;
  logic [23:0]      shift_reg;
  logic [23:0]      buf_data;
  logic             buf_valid;
  logic             req_pending;
  logic [4:0]       bit_cnt;
  logic [CYC_W-1:0] cyc_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [6:0]       word_cnt;
  logic [6:0]       req_cnt;

  logic       bit_end;
  logic       word_end;
  logic       rdy_take;
  logic       more_words;
  logic [6:0] cnt_clamped;

  assign bit_end     = (cyc_cnt == BIT_LAST);
  assign word_end    = bit_end && (bit_cnt == 5'd0);
  assign rdy_take    = word_rdy_in && req_pending;
  assign more_words  = (req_cnt < word_cnt);
  assign cnt_clamped = (word_cnt_in > 7'd64) ? 7'd64 : word_cnt_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      shift_reg       <= '0;
      buf_data        <= '0;
      buf_valid       <= 1'b0;
      req_pending     <= 1'b0;
      bit_cnt         <= '0;
      cyc_cnt         <= '0;
      lat_cnt         <= '0;
      word_cnt        <= '0;
      req_cnt         <= '0;
      word_req_out    <= 1'b0;
      word_idx_out    <= '0;
      ws2812_data_out <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
      underrun_out    <= 1'b0;
    end else begin
      word_req_out <= 1'b0;
      done_out     <= 1'b0;
      case (state)
        IDLE: begin
          ws2812_data_out <= 1'b0;
          if (frame_start_in) begin
            underrun_out <= 1'b0;
            if (cnt_clamped == 7'd0) begin
              done_out <= 1'b1;
            end else begin
              state        <= FETCH;
              busy_out     <= 1'b1;
              word_cnt     <= cnt_clamped;
              req_cnt      <= 7'd1;
              word_idx_out <= 6'd0;
              word_req_out <= 1'b1;
              req_pending  <= 1'b1;
              buf_valid    <= 1'b0;
            end
          end
        end

        FETCH: begin
          ws2812_data_out <= 1'b0;
          if (rdy_take) begin
            shift_reg   <= word_data_in;
            req_pending <= 1'b0;
            bit_cnt     <= 5'd23;
            cyc_cnt     <= '0;
            state       <= SEND;
          end
        end

        SEND: begin
          ws2812_data_out <= shift_reg[23] ? (cyc_cnt < T1H) : (cyc_cnt < T0H);
          // A word arriving on the final cycle of a word is loaded directly
          // below, so it only goes to the buffer on other cycles.
          if (rdy_take && !word_end) begin
            buf_data    <= word_data_in;
            buf_valid   <= 1'b1;
            req_pending <= 1'b0;
          end
          // Prefetch the next word at the very start of each word.
          if (bit_cnt == 5'd23 && cyc_cnt == '0 && more_words) begin
            word_req_out <= 1'b1;
            word_idx_out <= req_cnt[5:0];
            req_cnt      <= req_cnt + 7'd1;
            req_pending  <= 1'b1;
          end
          if (bit_end) begin
            cyc_cnt <= '0;
            if (bit_cnt != 5'd0) begin
              bit_cnt   <= bit_cnt - 5'd1;
              shift_reg <= {shift_reg[22:0], 1'b0};
            end else if (buf_valid) begin
              shift_reg <= buf_data;
              buf_valid <= 1'b0;
              bit_cnt   <= 5'd23;
            end else if (rdy_take) begin
              shift_reg   <= word_data_in;
              req_pending <= 1'b0;
              bit_cnt     <= 5'd23;
            end else if (req_pending) begin
              // Outstanding request stands; FETCH loads it when it arrives.
              underrun_out <= 1'b1;
              state        <= FETCH;
            end else begin
              state   <= LATCH;
              lat_cnt <= '0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        LATCH: begin
          ws2812_data_out <= 1'b0;
          if (lat_cnt == LAT_LAST) begin
            lat_cnt  <= '0;
            state    <= IDLE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ws2812_encoder.md
WS2812_ENCODER -- requirements
Module: ws2812_encoder

Interface
REQ-001 Parameter T0H_CYC, default 20: high time of a 0 bit, in clk_in cycles.
REQ-002 Parameter T1H_CYC, default 40: high time of a 1 bit, in clk_in cycles.
REQ-003 Parameter BIT_CYC, default 63: total bit period, in clk_in cycles; T0H_CYC < T1H_CYC < BIT_CYC.
REQ-004 Parameter RST_CYC, default 4000: latch (reset-low) duration, in clk_in cycles.
REQ-005 Port clk_in, input, 1: the only clock.
REQ-006 Port rst_in, input, 1: reset, synchronous, active-high.
REQ-007 Port frame_start_in, input, 1: one-cycle pulse that starts a frame.
REQ-008 Port word_cnt_in, input, 7: number of LEDs in the frame (0..64), sampled with frame_start_in.
REQ-009 Port word_req_out, output, 1: one-cycle request for the word at word_idx_out.
REQ-010 Port word_idx_out, output, 6: index of the requested word; valid while word_req_out=1.
REQ-011 Port word_rdy_in, input, 1: one-cycle strobe marking word_data_in valid for the last request.
REQ-012 Port word_data_in, input, 24: GRB pixel word, G[23:16] R[15:8] B[7:0].
REQ-013 Port ws2812_data_out, output, 1: serial WS2812 waveform.
REQ-014 Port busy_out, output, 1: high from frame acceptance until done_out.
REQ-015 Port done_out, output, 1: one-cycle pulse at frame completion.
REQ-016 Port underrun_out, output, 1: sticky flag; a word arrived too late to avoid an inter-word gap.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, SEND and LATCH.
REQ-018 IDLE: ws2812_data_out=0 and busy_out=0.
- frame_start_in with word_cnt_in>0 -> FETCH; word_idx=0; busy_out=1 on the next cycle.
- frame_start_in with word_cnt_in=0 -> stay in IDLE; done_out pulses on the next cycle.
- word_cnt_in values >64 SHALL be clamped to 64.
REQ-019 FETCH: word_req_out SHALL pulse exactly once, on the first FETCH cycle; then wait indefinitely for word_rdy_in with ws2812_data_out=0.
- On word_rdy_in: load the shift register and enter SEND on the next cycle with bit_cnt=23, cyc_cnt=0.
REQ-020 SEND: bits SHALL be sent MSB first.
- ws2812_data_out=1 while cyc_cnt < T0H_CYC (bit=0) or cyc_cnt < T1H_CYC (bit=1), otherwise 0.
- cyc_cnt counts 0..BIT_CYC-1, then wraps and bit_cnt decrements.
REQ-021 Prefetch: on the SEND cycle with bit_cnt=23 and cyc_cnt=0, if words remain, word_req_out SHALL pulse with word_idx_out = current+1.
- A word_rdy_in arriving after that request SHALL be stored in a one-word buffer and mark it valid.
REQ-022 End of bit 0 (cyc_cnt=BIT_CYC-1, bit_cnt=0):
- Last word -> LATCH.
- Buffer valid -> load the buffer, clear valid and continue SEND with no gap cycle.
- Buffer not valid -> set underrun_out and go to FETCH without a new request (the outstanding request stands). The next word_rdy_in then loads directly.
REQ-023 A word_rdy_in with no outstanding request SHALL be ignored.
REQ-024 LATCH: hold ws2812_data_out=0 for RST_CYC cycles, then pulse done_out and return to IDLE with busy_out=0 in the same cycle.
REQ-025 frame_start_in while busy_out=1 SHALL be ignored.
REQ-026 Counter widths SHALL be sized from the parameters; no counter SHALL overflow at the maximum parameter values.
REQ-027 underrun_out SHALL clear only on reset or on an accepted frame_start_in.

Reset
REQ-028 While rst_in=1 at a clk_in edge, the block SHALL set:
- state=IDLE
- ws2812_data_out=0, word_req_out=0, word_idx_out=0, busy_out=0, done_out=0, underrun_out=0
- buffer valid=0, all counters 0
REQ-029 A reset mid-frame SHALL abort the frame with no done_out pulse; a word_rdy_in arriving after reset SHALL be ignored.

Verification
REQ-030 word_cnt=1, data 0xFF0000, word_rdy 2 cycles after request:
- 8 pulses of 40 high / 23 low, then 16 pulses of 20 high / 43 low.
- Then 4000 low cycles, then done_out pulse; busy_out covers exactly that span.
REQ-031 word_cnt=3, each word_rdy 3 cycles after request:
- Exactly 3 requests with idx 0,1,2.
- 72 contiguous bit periods with no gap; underrun_out=0.
REQ-032 word_cnt=2, second word_rdy delayed 2000 cycles after its request:
- Line stays low during the wait; underrun_out=1.
- Second word transmits correctly once it arrives.
REQ-033 frame_start with word_cnt=0:
- No request; done_out one cycle later; line stays low.
- frame_start during an active frame is ignored; the frame is unchanged.
REQ-034 rst_in asserted at bit 10 of word 1 of a 4-word frame:
- Next cycle all outputs match their reset values.
- A late word_rdy_in is ignored; a new frame_start succeeds.
